fetch_ir_unit: RTL and testbench

- Instruction-fetch and instruction-register stage feeding the multicycle control unit and ALU control.
- Holds the PC and issues a single-beat instruction read to memory with a req/ready handshake and a bounded wait.
- Latches the returned word into the IR and presents the decoded fields: opcode to the control unit; funct3/funct7 bit to ALU control; rd/rs1/rs2 to the register file.
- Driven by the control FSM's weIR (fetch start) and wePc (PC update) strobes.

---
 rtl/fetch_ir_unit.sv | 109 ++++++++++
 tb/tb_fetch_ir_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ir_unit.sv
// fetch_ir_unit: PC register, single-beat instruction fetch with bounded wait, and IR with decoded fields.
module fetch_ir_unit #(
    parameter int unsigned    PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned    MAX_WAIT = 8,
    parameter logic [31:0]    NOP_WORD = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            weIR,
    input  logic            wePc,
    input  logic            pc_sel,
    input  logic [PC_W-1:0] branch_target,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    output logic [31:0]     ir,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            funct7,
    output logic [PC_W-1:0] pc,
    output logic            instr_valid,
    output logic            busy,
    output logic            fetch_err
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, addr_q, addr_d, pend_pc_q, pend_pc_d, next_pc;
    logic            pend_q, pend_d, valid_q, valid_d, err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [31:0]     ir_q, ir_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            pend_pc_q <= RESET_PC;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
            ir_q      <= NOP_WORD;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            pend_pc_q <= pend_pc_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
        end
    end
    always_comb begin
        next_pc   = pc_sel ? (branch_target & ~PC_W'(3)) : pc_q + PC_W'(4);
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        pend_pc_d = pend_pc_q;
        pend_d    = pend_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        if (state_q == S_IDLE) begin
            if (weIR) begin
                state_d = S_WAIT;
                addr_d  = pc_q;
                cnt_d   = 8'd0;
                pend_d  = 1'b0;
            end
            if (wePc) pc_d = next_pc;
        end else begin
            // PC updates during a fetch are deferred; the latest one wins on exit
            if (wePc) begin
                pend_d    = 1'b1;
                pend_pc_d = next_pc;
            end
            if (mem_ready || cnt_q == 8'(MAX_WAIT - 1)) begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
                pc_d    = wePc ? next_pc : (pend_q ? pend_pc_q : pc_q);
                ir_d    = mem_ready ? mem_rdata : ir_q;
                valid_d = mem_ready;
                err_d   = err_q | ~mem_ready;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end
    assign mem_req     = (state_q == S_WAIT);
    assign busy        = (state_q == S_WAIT);
    assign mem_addr    = addr_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign opcode      = ir_q[6:0];
    assign rd          = ir_q[11:7];
    assign funct3      = ir_q[14:12];
    assign rs1         = ir_q[19:15];
    assign rs2         = ir_q[24:20];
    assign funct7      = ir_q[30];
endmodule

// File: tb/tb_fetch_ir_unit.sv
// tb_fetch_ir_unit: directed scenarios for fetch_ir_unit with hand-computed expectations.
module tb_fetch_ir_unit;
    logic        clk = 1'b0, reset = 1'b1, weIR = 1'b0, wePc = 1'b0, pc_sel = 1'b0, mem_ready = 1'b0;
    logic [31:0] branch_target = 32'h0, mem_rdata = 32'h0;
    logic        mem_req, instr_valid, busy, fetch_err, funct7;
    logic [31:0] mem_addr, ir, pc;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    int          vecs = 0, errs = 0;

    fetch_ir_unit dut (
        .clk(clk), .reset(reset), .weIR(weIR), .wePc(wePc), .pc_sel(pc_sel),
        .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ir(ir), .opcode(opcode),
        .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .pc(pc),
        .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        vecs++; if (pc !== 32'h0) begin errs++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        vecs++; if (ir !== 32'h13) begin errs++; $display("FAIL reset_ir got %h exp %h", ir, 32'h13); end
        vecs++; if ({mem_req, busy, instr_valid, fetch_err} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b exp 0000", {mem_req, busy, instr_valid, fetch_err}); end
        vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL reset_addr got %h exp %h", mem_addr, 32'h0); end
    endtask

    task automatic test_fetch;
        weIR = 1'b1;
        cyc();
        weIR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vecs++; if ({mem_req, busy, instr_valid} !== 3'b110) begin errs++; $display("FAIL fetch_req[%0d] got %b exp 110", i, {mem_req, busy, instr_valid}); end
            vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL fetch_addr[%0d] got %h exp 0", i, mem_addr); end
            if (i == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h0020_8033;
            end
            cyc();
        end
        mem_ready = 1'b0;
        vecs++; if (ir !== 32'h0020_8033) begin errs++; $display("FAIL fetch_ir got %h exp 00208033", ir); end
        vecs++; if ({opcode, rd, rs1, rs2, funct3, funct7} !== {7'h33, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0})
            begin errs++; $display("FAIL fetch_fields got op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%0d exp 33/0/1/2/0/0", opcode, rd, rs1, rs2, funct3, funct7); end
        vecs++; if ({mem_req, busy, instr_valid} !== 3'b001) begin errs++; $display("FAIL fetch_done got %b exp 001", {mem_req, busy, instr_valid}); end
        cyc();
        vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL valid_pulse got %b exp 0", instr_valid); end
    endtask

    task automatic test_pc_update;
        wePc = 1'b1;
        pc_sel = 1'b0;
        cyc(3);
        vecs++; if (pc !== 32'hC) begin errs++; $display("FAIL pc_inc got %h exp 0000000c", pc); end
        pc_sel = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        cyc();
        vecs++; if (pc !== 32'hFFFF_FFFC) begin errs++; $display("FAIL pc_align_hi got %h exp fffffffc", pc); end
        pc_sel = 1'b0;
        cyc();
        vecs++; if (pc !== 32'h0) begin errs++; $display("FAIL pc_wrap got %h exp 0", pc); end
        pc_sel = 1'b1;
        branch_target = 32'h0000_0107;
        cyc();
        wePc = 1'b0;
        pc_sel = 1'b0;
        vecs++; if (pc !== 32'h104) begin errs++; $display("FAIL pc_branch got %h exp 00000104", pc); end
        cyc();
        vecs++; if (pc !== 32'h104) begin errs++; $display("FAIL pc_hold got %h exp 00000104", pc); end
    endtask

    task automatic test_idle_ready;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        cyc(2);
        mem_ready = 1'b0;
        vecs++; if ({instr_valid, ir} !== {1'b0, 32'h0020_8033}) begin errs++; $display("FAIL idle_ready got v=%b ir=%h exp v=0 ir=00208033", instr_valid, ir); end
    endtask

    task automatic test_timeout;
        weIR = 1'b1;
        cyc();
        weIR = 1'b0;
        cyc(7);
        vecs++; if ({mem_req, fetch_err} !== 2'b10) begin errs++; $display("FAIL timeout_early got req,err=%b exp 10", {mem_req, fetch_err}); end
        vecs++; if (mem_addr !== 32'h104) begin errs++; $display("FAIL timeout_addr got %h exp 00000104", mem_addr); end
        cyc();
        vecs++; if ({mem_req, busy, fetch_err, instr_valid} !== 4'b0010) begin errs++; $display("FAIL timeout got req,busy,err,v=%b exp 0010", {mem_req, busy, fetch_err, instr_valid}); end
        vecs++; if (ir !== 32'h0020_8033) begin errs++; $display("FAIL timeout_ir got %h exp 00208033", ir); end
        weIR = 1'b1;
        cyc();
        weIR = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h4000_0533;
        cyc();
        mem_ready = 1'b0;
        vecs++; if ({instr_valid, fetch_err, ir} !== {2'b11, 32'h4000_0533}) begin errs++; $display("FAIL after_err got v=%b err=%b ir=%h exp v=1 err=1 ir=40000533", instr_valid, fetch_err, ir); end
        vecs++; if ({funct7, rd} !== {1'b1, 5'd10}) begin errs++; $display("FAIL after_err_fields got f7=%b rd=%0d exp 1/10", funct7, rd); end
    endtask

    task automatic test_ready_at_limit;
        test_reset();
        weIR = 1'b1;
        cyc();
        weIR = 1'b0;
        cyc(7);
        mem_ready = 1'b1;
        mem_rdata = 32'h00C5_8593;
        cyc();
        mem_ready = 1'b0;
        vecs++; if ({instr_valid, fetch_err, mem_req} !== 3'b100) begin errs++; $display("FAIL limit_ready got v,err,req=%b exp 100", {instr_valid, fetch_err, mem_req}); end
        vecs++; if (ir !== 32'h00C5_8593) begin errs++; $display("FAIL limit_ir got %h exp 00c58593", ir); end
    endtask

    task automatic test_pending_pc;
        wePc = 1'b1;
        pc_sel = 1'b1;
        branch_target = 32'h10;
        cyc();
        wePc = 1'b0;
        weIR = 1'b1;
        cyc();
        weIR = 1'b0;
        vecs++; if (mem_addr !== 32'h10) begin errs++; $display("FAIL pend_addr0 got %h exp 00000010", mem_addr); end
        wePc = 1'b1;
        pc_sel = 1'b1;
        branch_target = 32'h40;
        cyc();
        vecs++; if ({pc, mem_addr} !== {32'h10, 32'h10}) begin errs++; $display("FAIL pend_hold got pc=%h addr=%h exp 10/10", pc, mem_addr); end
        pc_sel = 1'b0;
        cyc();
        wePc = 1'b0;
        vecs++; if ({pc, mem_addr} !== {32'h10, 32'h10}) begin errs++; $display("FAIL pend_hold2 got pc=%h addr=%h exp 10/10", pc, mem_addr); end
        cyc();
        vecs++; if (pc !== 32'h10) begin errs++; $display("FAIL pend_idle got %h exp 00000010", pc); end
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        vecs++; if ({pc, mem_addr, instr_valid} !== {32'h14, 32'h10, 1'b1}) begin errs++; $display("FAIL pend_apply got pc=%h addr=%h v=%b exp 14/10/1", pc, mem_addr, instr_valid); end
    endtask

    task automatic test_back_to_back;
        weIR = 1'b1;
        wePc = 1'b1;
        pc_sel = 1'b0;
        cyc();
        weIR = 1'b0;
        wePc = 1'b0;
        vecs++; if ({mem_addr, pc, mem_req} !== {32'h14, 32'h18, 1'b1}) begin errs++; $display("FAIL both_strobes got addr=%h pc=%h req=%b exp 14/18/1", mem_addr, pc, mem_req); end
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0013;
        cyc();
        mem_ready = 1'b0;
        vecs++; if ({instr_valid, pc} !== {1'b1, 32'h18}) begin errs++; $display("FAIL both_done got v=%b pc=%h exp 1/18", instr_valid, pc); end
    endtask

    task automatic test_reset_abort;
        weIR = 1'b1;
        cyc();
        weIR = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        vecs++; if ({mem_req, busy} !== 2'b00) begin errs++; $display("FAIL abort_req got req,busy=%b exp 00", {mem_req, busy}); end
        mem_ready = 1'b1;
        mem_rdata = 32'hABCD_1234;
        cyc();
        mem_ready = 1'b0;
        vecs++; if ({instr_valid, mem_req, ir, pc} !== {2'b00, 32'h13, 32'h0}) begin errs++; $display("FAIL abort got v=%b req=%b ir=%h pc=%h exp 0/0/00000013/0", instr_valid, mem_req, ir, pc); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_pc_update();
        test_idle_ready();
        test_timeout();
        test_ready_at_limit();
        test_pending_pc();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
